// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters; accept->rsp_valid after 2 edges.
// One operation in flight: req_ready stays low until the result is taken (rsp_valid held while !rsp_ready).
module adder #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin
);
  assign out = A + B + {{(WIDTH-1){1'b0}}, Cin};
endmodule

module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic [3:0]            rsp_flags
);
  localparam int IDW = 2;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_op_id;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_cin;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_sum;
  flags_t           r_flags;

  logic [IDW-1:0]   w_gnt;
  logic             w_gnt_vld;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_sum;
  flags_t           w_flags;

  // Scan downward so the requester closest to r_ptr is the one left standing
  always_comb begin
    w_gnt     = r_ptr;
    w_gnt_vld = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_valid[r_ptr + IDW'(k)]) begin
        w_gnt     = r_ptr + IDW'(k);
        w_gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && !reset && w_gnt_vld) begin
      req_ready[w_gnt] = 1'b1;
    end
  end

  assign w_sel_a = req_a[w_gnt*WIDTH +: WIDTH];
  assign w_sel_b = req_b[w_gnt*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_vld) w_state_nxt = CALC;
      CALC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .out (w_sum),
    .A   (r_op_a),
    .B   (r_op_b),
    .Cin (r_op_cin)
  );

  // Flags use the already-inverted B so subtract reports carry as not-borrow
  always_comb begin
    w_flags.n = w_sum[WIDTH-1];
    w_flags.z = (w_sum == '0);
    w_flags.c = (r_op_a[WIDTH-1] & r_op_b[WIDTH-1]) |
                ((r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1]) & ~w_sum[WIDTH-1]);
    w_flags.v = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_op_a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_op_id   <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_cin  <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_sum <= '0;
      r_flags   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= req_sub[w_gnt] ? ~w_sel_b : w_sel_b;
            r_op_cin <= req_sub[w_gnt] | req_cin[w_gnt];
            r_op_id  <= w_gnt;
          end
        end
        CALC: begin
          r_rsp_sum <= w_sum;
          r_flags   <= w_flags;
          r_rsp_id  <= r_op_id;
        end
        RESP: begin
          if (rsp_ready) r_ptr <= r_op_id + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_flags = r_flags;
endmodule
